// File: rtl/spd_level_ctrl_if.sv
// rtl/spd_level_ctrl_if.sv - button inputs and speed-code outputs of the speed-level controller
interface spd_level_ctrl_if;
  logic btn_up;
  logic btn_down;
  logic btn_stop;
  logic spd_a;
  logic spd_b;
  logic spd_chg;
  logic dwell_bsy;

  modport master (
    output btn_up, btn_down, btn_stop,
    input  spd_a, spd_b, spd_chg, dwell_bsy
  );

  modport slave (
    input  btn_up, btn_down, btn_stop,
    output spd_a, spd_b, spd_chg, dwell_bsy
  );
endinterface

// File: rtl/spd_level_ctrl.sv
// rtl/spd_level_ctrl.sv - debounced UP/DOWN/STOP speed-level FSM; optional SPD_AUTO_IDLE_EN idle step-down
module spd_level_ctrl #(
  parameter int DB_CYCLES    = 16,
  parameter int DWELL_CYCLES = 8,
  parameter int IDLE_CYCLES  = 64,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  spd_level_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYCLES);

  // Button index: 0 = UP, 1 = DOWN, 2 = STOP
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q, db_q, db_d1_q, blk_q;
  logic [1:0]       fill_q;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [2:0]       press;

  state_e           state_q, state_d;
  logic             chg_q;
  logic [CNT_W-1:0] dwell_cnt_q;
  logic             dwell_act;
  logic             press_acc;

  assign raw   = {bus.btn_stop, bus.btn_down, bus.btn_up};
  // blk_q masks a level that was already high when reset released
  assign press = db_q & ~db_d1_q & ~blk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      db_d1_q <= '0;
      blk_q   <= 3'b111;
      fill_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_d1_q <= db_q;
      fill_q  <= {fill_q[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          db_q[i]     <= ~db_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
        if (fill_q[1] && !sync2_q[i] && !db_q[i]) blk_q[i] <= 1'b0;
      end
    end
  end

  assign dwell_act = (dwell_cnt_q != '0);

`ifdef SPD_AUTO_IDLE_EN
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  logic [CNT_W-1:0] idle_q;
  logic             idle_to;
  assign idle_to = (state_q != ST_STOP) && (idle_q == IDLE_LAST);
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^{IDLE_CYCLES, press_acc};
`endif

  always_comb begin
    state_d   = state_q;
    press_acc = 1'b0;
    if (press[2]) begin
      state_d   = ST_STOP;
      press_acc = 1'b1;
    end else if (!dwell_act && (press[0] ^ press[1])) begin
      press_acc = 1'b1;
      if (press[0]) begin
        case (state_q)
          ST_STOP: state_d = ST_LOW;
          ST_LOW:  state_d = ST_HIGH;
          ST_HIGH: state_d = ST_HIGH;
          default: state_d = ST_STOP;
        endcase
      end else begin
        case (state_q)
          ST_HIGH: state_d = ST_LOW;
          default: state_d = ST_STOP;
        endcase
      end
    end
`ifdef SPD_AUTO_IDLE_EN
    else if (idle_to) begin
      state_d = (state_q == ST_HIGH) ? ST_LOW : ST_STOP;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      chg_q       <= 1'b0;
      dwell_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      chg_q   <= (state_d != state_q);
      if (state_d != state_q)  dwell_cnt_q <= DWELL_LD;
      else if (dwell_act)      dwell_cnt_q <= dwell_cnt_q - CNT_W'(1);
    end
  end

`ifdef SPD_AUTO_IDLE_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                 idle_q <= '0;
    else if ((state_d != state_q) || press_acc) idle_q <= '0;
    else if (state_q != ST_STOP)                idle_q <= idle_q + CNT_W'(1);
    else                                        idle_q <= '0;
  end
`endif

  assign bus.spd_a     = state_q[1];
  assign bus.spd_b     = state_q[0];
  assign bus.spd_chg   = chg_q;
  assign bus.dwell_bsy = dwell_act;

endmodule

// File: tb/tb_spd_level_ctrl.sv
// tb/tb_spd_level_ctrl.sv - self-checking bench for spd_level_ctrl, directed scenarios plus randomized button traffic
module tb_spd_level_ctrl;
  localparam int DB   = 16;
  localparam int DW   = 8;
  localparam int IDLE = 64;
  localparam int LAT  = DB + 3;
  localparam int RN   = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spd_level_ctrl_if bus ();

  spd_level_ctrl #(
    .DB_CYCLES(DB), .DWELL_CYCLES(DW), .IDLE_CYCLES(IDLE), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic plan [3][RN];
  logic pev  [3][RN + LAT + 2];

  function automatic logic [1:0] code();
    return {bus.spd_a, bus.spd_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: bus.btn_up = v;
      1: bus.btn_down = v;
      default: bus.btn_stop = v;
    endcase
  endtask

  task automatic hit(input int b);
    set_btn(b, 1'b1);
    repeat (LAT) tick();
    set_btn(b, 1'b0);
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_up = 1'b1;
    repeat (3) tick();
    n_chk++; if (code() !== 2'b00) begin n_fail++; $display("FAIL reset_spd got=%b exp=00", code()); end
    n_chk++; if (bus.spd_chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg got=%b exp=0", bus.spd_chg); end
    n_chk++; if (bus.dwell_bsy !== 1'b0) begin n_fail++; $display("FAIL reset_bsy got=%b exp=0", bus.dwell_bsy); end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_chk++;
      if ({code(), bus.spd_chg} !== 3'b000) begin
        n_fail++; $display("FAIL held_through_reset cyc=%0d got=%b%b exp=000", i, code(), bus.spd_chg);
      end
    end
    bus.btn_up = 1'b0;
    settle(30);
  endtask

  task automatic test_clean_up();
    bus.btn_up = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k < LAT) begin
        n_chk++;
        if ({code(), bus.spd_chg} !== 3'b000) begin
          n_fail++; $display("FAIL up_early edge=%0d got=%b%b exp=000", k, code(), bus.spd_chg);
        end
      end
    end
    n_chk++; if (code() !== 2'b01) begin n_fail++; $display("FAIL up_step got=%b exp=01", code()); end
    n_chk++; if (bus.spd_chg !== 1'b1) begin n_fail++; $display("FAIL up_chg got=%b exp=1", bus.spd_chg); end
    n_chk++; if (bus.dwell_bsy !== 1'b1) begin n_fail++; $display("FAIL up_bsy got=%b exp=1", bus.dwell_bsy); end
    for (int k = 1; k <= DW; k++) begin
      tick();
      n_chk++;
      if ({code(), bus.spd_chg, bus.dwell_bsy} !== {2'b01, 1'b0, (k < DW)}) begin
        n_fail++; $display("FAIL dwell_len k=%0d got=%b%b%b exp=010%b", k, code(), bus.spd_chg, bus.dwell_bsy, (k < DW));
      end
    end
    bus.btn_up = 1'b0;
    settle(30);
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 60; c++) begin
      bus.btn_up = ((c / 5) % 2 == 0);
      tick();
      n_chk++;
      if ({code(), bus.spd_chg} !== 3'b010) begin
        n_fail++; $display("FAIL bounce_hold cyc=%0d got=%b%b exp=010", c, code(), bus.spd_chg);
      end
    end
    bus.btn_up = 1'b1;
    for (int k = 1; k < LAT; k++) begin
      tick();
      n_chk++;
      if (code() !== 2'b01) begin n_fail++; $display("FAIL bounce_early edge=%0d got=%b exp=01", k, code()); end
    end
    tick();
    n_chk++;
    if ({code(), bus.spd_chg} !== 3'b101) begin
      n_fail++; $display("FAIL bounce_step got=%b%b exp=101", code(), bus.spd_chg);
    end
    bus.btn_up = 1'b0;
    settle(30);
  endtask

  task automatic test_dwell_down();
    hit(2);
    n_chk++; if (code() !== 2'b00) begin n_fail++; $display("FAIL stop_from_high got=%b exp=00", code()); end
    settle(25);
    hit(0);
    settle(25);
    bus.btn_up = 1'b1;
    repeat (3) tick();
    bus.btn_down = 1'b1;
    repeat (LAT - 3) tick();
    n_chk++;
    if ({code(), bus.spd_chg} !== 3'b101) begin n_fail++; $display("FAIL dwell_setup got=%b%b exp=101", code(), bus.spd_chg); end
    bus.btn_up = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick();
      n_chk++;
      if ({code(), bus.spd_chg} !== 3'b100) begin
        n_fail++; $display("FAIL down_in_dwell k=%0d got=%b%b exp=100", k, code(), bus.spd_chg);
      end
    end
    bus.btn_down = 1'b0;
    settle(30);
    hit(1);
    n_chk++; if ({code(), bus.spd_chg} !== 3'b011) begin n_fail++; $display("FAIL down_high got=%b%b exp=011", code(), bus.spd_chg); end
    settle(25);
    hit(1);
    n_chk++; if ({code(), bus.spd_chg} !== 3'b001) begin n_fail++; $display("FAIL down_low got=%b%b exp=001", code(), bus.spd_chg); end
    settle(25);
    hit(1);
    n_chk++;
    if ({code(), bus.spd_chg, bus.dwell_bsy} !== 4'b0000) begin
      n_fail++; $display("FAIL down_saturate got=%b%b%b exp=0000", code(), bus.spd_chg, bus.dwell_bsy);
    end
    settle(25);
  endtask

  task automatic test_stop_priority();
    hit(0);
    settle(25);
    bus.btn_up = 1'b1;
    bus.btn_stop = 1'b1;
    repeat (LAT) tick();
    n_chk++; if ({code(), bus.spd_chg} !== 3'b001) begin n_fail++; $display("FAIL stop_up_same got=%b%b exp=001", code(), bus.spd_chg); end
    tick();
    n_chk++; if ({code(), bus.spd_chg} !== 3'b000) begin n_fail++; $display("FAIL stop_up_once got=%b%b exp=000", code(), bus.spd_chg); end
    bus.btn_up = 1'b0;
    bus.btn_stop = 1'b0;
    settle(30);
    hit(0);
    settle(25);
    bus.btn_up = 1'b1;
    repeat (5) tick();
    bus.btn_stop = 1'b1;
    repeat (LAT - 5) tick();
    n_chk++; if (code() !== 2'b10) begin n_fail++; $display("FAIL reach_high got=%b exp=10", code()); end
    bus.btn_up = 1'b0;
    repeat (4) tick();
    n_chk++; if ({code(), bus.dwell_bsy} !== 3'b101) begin n_fail++; $display("FAIL pre_stop got=%b%b exp=101", code(), bus.dwell_bsy); end
    tick();
    n_chk++;
    if ({code(), bus.spd_chg, bus.dwell_bsy} !== 4'b0011) begin
      n_fail++; $display("FAIL stop_in_dwell got=%b%b%b exp=0011", code(), bus.spd_chg, bus.dwell_bsy);
    end
    bus.btn_stop = 1'b0;
    settle(30);
  endtask

  task automatic test_random();
    int t, h, e, lvl, nl, last_chg, last_act;
    logic u, d, s, acc, chgd, busy;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < RN; i++) plan[b][i] = 1'b0;
      for (int i = 0; i < RN + LAT + 2; i++) pev[b][i] = 1'b0;
      t = 3 + int'($urandom_range(0, 20));
      while (t < RN - 40) begin
        h = DB + 2 + int'($urandom_range(0, 8));
        for (int i = t; i < t + h; i++) plan[b][i] = 1'b1;
        pev[b][t + LAT] = 1'b1;
        t += h + DB + 4 + int'($urandom_range(0, (b == 2) ? 160 : 35));
      end
    end
    lvl = 0;
    last_chg = -100;
    last_act = 0;
    for (int c = 0; c <= RN + LAT; c++) begin
      bus.btn_up   = (c < RN) ? plan[0][c] : 1'b0;
      bus.btn_down = (c < RN) ? plan[1][c] : 1'b0;
      bus.btn_stop = (c < RN) ? plan[2][c] : 1'b0;
      tick();
      e = c + 1;
      u = pev[0][e]; d = pev[1][e]; s = pev[2][e];
      busy = (e - last_chg) <= DW;
      nl = lvl;
      acc = 1'b0;
      if (s) begin
        nl = 0; acc = 1'b1;
      end else if (!busy && (u != d)) begin
        acc = 1'b1;
        nl = u ? ((lvl < 2) ? lvl + 1 : 2) : ((lvl > 0) ? lvl - 1 : 0);
      end
`ifdef SPD_AUTO_IDLE_EN
      else if (lvl != 0 && (e - last_act) == IDLE) begin
        nl = lvl - 1;
      end
`endif
      chgd = (nl != lvl);
      if (chgd) last_chg = e;
      if (chgd || acc) last_act = e;
      lvl = nl;
      n_chk++;
      if (code() !== 2'(lvl)) begin n_fail++; $display("FAIL rand_spd edge=%0d got=%b exp=%b", e, code(), 2'(lvl)); end
      n_chk++;
      if (bus.spd_chg !== chgd) begin n_fail++; $display("FAIL rand_chg edge=%0d got=%b exp=%b", e, bus.spd_chg, chgd); end
      n_chk++;
      if (bus.dwell_bsy !== ((e - last_chg) < DW)) begin
        n_fail++; $display("FAIL rand_bsy edge=%0d got=%b exp=%b", e, bus.dwell_bsy, ((e - last_chg) < DW));
      end
    end
    settle(30);
    hit(2);
    settle(30);
  endtask

  task automatic test_idle();
    hit(0);
    settle(25);
    hit(0);
    n_chk++; if (code() !== 2'b10) begin n_fail++; $display("FAIL idle_setup got=%b exp=10", code()); end
`ifdef SPD_AUTO_IDLE_EN
    for (int k = 1; k <= 2 * IDLE; k++) begin
      tick();
      n_chk++;
      if ({code(), bus.spd_chg} !== {((k < IDLE) ? 2'b10 : (k < 2 * IDLE) ? 2'b01 : 2'b00), (k == IDLE || k == 2 * IDLE)}) begin
        n_fail++; $display("FAIL idle_step k=%0d got=%b%b", k, code(), bus.spd_chg);
      end
    end
`else
    for (int k = 1; k <= 1000; k++) begin
      tick();
      n_chk++;
      if ({code(), bus.spd_chg} !== 3'b100) begin
        n_fail++; $display("FAIL idle_hold k=%0d got=%b%b exp=100", k, code(), bus.spd_chg);
      end
    end
`endif
  endtask

  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_stop = 1'b0;
    test_reset();
    test_clean_up();
    test_bounce();
    test_dwell_down();
    test_stop_priority();
    test_random();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
